// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg
//   Shared definitions for the key debouncer: the per-channel FSM state
//   encoding, default timing constants and a counter-width helper.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } key_state_e;

  localparam int unsigned DEF_N_KEYS          = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;   // 10 ms at 100 MHz
  localparam int unsigned DEF_HOLD_CYCLES     = 50000000;  // 500 ms before first repeat
  localparam int unsigned DEF_REPEAT_CYCLES   = 10000000;  // 100 ms between repeats

  // Bits needed for a counter that runs 0 .. max_count-1 (at least 1 bit).
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count <= 2) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/key_debounce_if.sv
// key_debounce_if
//   Bundles the raw key inputs and the per-key event outputs of the debouncer.
//   master: the side that owns the buttons and consumes the events.
//   slave : the debouncer itself.
//   key_i     raw active-low buttons (0 = pressed)
//   state_o   debounced level, 1 = pressed
//   press_o   one-cycle pulse on accepted press
//   release_o one-cycle pulse on accepted release
//   repeat_o  one-cycle auto-repeat pulse while held
interface key_debounce_if #(
  parameter int unsigned N_KEYS = key_debounce_pkg::DEF_N_KEYS
) ();

  logic [N_KEYS-1:0] key_i;
  logic [N_KEYS-1:0] state_o;
  logic [N_KEYS-1:0] press_o;
  logic [N_KEYS-1:0] release_o;
  logic [N_KEYS-1:0] repeat_o;

  modport master (
    output key_i,
    input  state_o, press_o, release_o, repeat_o
  );

  modport slave (
    input  key_i,
    output state_o, press_o, release_o, repeat_o
  );

endinterface

// File: rtl/key_debounce_ch.sv
// key_debounce_ch
//   One key channel: 2-flop synchronizer, debounce FSM, hold/repeat timers.
//   clk100_i   system clock (rising edge)
//   rstn_i     asynchronous active-low reset
//   key_i      raw active-low button
//   state_o    debounced level, 1 = pressed
//   press_o    registered one-cycle press pulse
//   release_o  registered one-cycle release pulse
//   repeat_o   registered one-cycle auto-repeat pulse
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk100_i,
  input  logic rstn_i,
  input  logic key_i,
  output logic state_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int unsigned DEB_W  = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = cnt_width(HOLD_CYCLES);
  localparam int unsigned REP_W  = cnt_width(REPEAT_CYCLES);
  localparam bit          REPEAT_EN = (HOLD_CYCLES != 0);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(REPEAT_EN ? HOLD_CYCLES - 1 : 0);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  logic [1:0]        sync_q;
  logic              key_s;
  key_state_e        state_q,     state_d;
  logic [DEB_W-1:0]  deb_cnt_q,   deb_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;
  logic [REP_W-1:0]  rep_cnt_q,   rep_cnt_d;
  logic              repeating_q, repeating_d;
  logic              press_q,     press_d;
  logic              release_q,   release_d;
  logic              repeat_q,    repeat_d;

  // NOTE: synchronizer flops reset to 1 (released) so a key held through
  // reset is seen as a fresh falling edge and re-debounced afterwards.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_i};
    end
  end

  assign key_s = sync_q[1];

  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      rep_cnt_q   <= '0;
      repeating_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      repeating_q <= repeating_d;
      press_q     <= press_d;
      release_q   <= release_d;
      repeat_q    <= repeat_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    repeating_d = repeating_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    repeat_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!key_s) begin
          state_d   = ST_PRESS_WAIT;
          deb_cnt_d = '0;
        end
      end

      ST_PRESS_WAIT: begin
        if (key_s) begin
          state_d = ST_IDLE;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d     = ST_HELD;
          press_d     = 1'b1;
          hold_cnt_d  = '0;
          rep_cnt_d   = '0;
          repeating_d = 1'b0;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end

      ST_HELD: begin
        if (key_s) begin
          // Hold/repeat counters keep their values while the release is
          // being qualified; a bounce resumes the schedule where it stopped.
          state_d   = ST_RELEASE_WAIT;
          deb_cnt_d = '0;
        end else if (REPEAT_EN) begin
          // Counters stop at their terminal value instead of wrapping, so
          // the first-repeat phase can never fire a second time.
          if (!repeating_q) begin
            if (hold_cnt_q == HOLD_LAST) begin
              repeat_d    = 1'b1;
              repeating_d = 1'b1;
              rep_cnt_d   = '0;
            end else begin
              hold_cnt_d = hold_cnt_q + 1'b1;
            end
          end else if (rep_cnt_q == REP_LAST) begin
            repeat_d  = 1'b1;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
        end
      end

      ST_RELEASE_WAIT: begin
        if (!key_s) begin
          state_d = ST_HELD;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign state_o   = (state_q == ST_HELD) || (state_q == ST_RELEASE_WAIT);
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_debounce.sv
// key_debounce
//   N_KEYS independent push-button debouncers with press/release/auto-repeat
//   events. One key_debounce_ch instance per key.
//   clk100_i  system clock (rising edge)
//   rstn_i    asynchronous active-low reset
//   bus       key_debounce_if.slave: key_i in; state_o, press_o,
//             release_o, repeat_o out (all N_KEYS wide)
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned N_KEYS          = DEF_N_KEYS,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input logic          clk100_i,
  input logic          rstn_i,
  key_debounce_if.slave bus
);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_ch (
      .clk100_i  (clk100_i),
      .rstn_i    (rstn_i),
      .key_i     (bus.key_i[g]),
      .state_o   (bus.state_o[g]),
      .press_o   (bus.press_o[g]),
      .release_o (bus.release_o[g]),
      .repeat_o  (bus.repeat_o[g])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce
//   Scenario tasks plus randomized runs, checked against a run-length
//   reference model of the debouncer kept in this file.
module tb_key_debounce;

  localparam int N = 2;
  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 5;

  logic clk100_i = 1'b0;
  logic rstn_i   = 1'b0;
  always #5 clk100_i = ~clk100_i;

  key_debounce_if #(.N_KEYS(N)) key_bus ();

  key_debounce #(
    .N_KEYS          (N),
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (H),
    .REPEAT_CYCLES   (R)
  ) dut (
    .clk100_i (clk100_i),
    .rstn_i   (rstn_i),
    .bus      (key_bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // ---------------- reference model ----------------
  // The FSM sees the raw key two edges late. A press is accepted when the
  // delayed key has been 0 for D+1 consecutive edges while released (one
  // edge to leave idle plus D counted edges); release mirrors it. Hold time
  // counts edges spent pressed with the key low on this and the previous
  // edge; repeats fire on hold count H, H+R, H+2R, ...
  bit [N-1:0] m_h1, m_h2, m_prev, m_level;
  bit [N-1:0] exp_press, exp_release, exp_repeat;
  int         m_run [N];
  int         m_adv [N];

  always @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      m_h1 = '1; m_h2 = '1; m_prev = '1; m_level = '0;
      exp_press = '0; exp_release = '0; exp_repeat = '0;
      for (int i = 0; i < N; i++) begin
        m_run[i] = 0;
        m_adv[i] = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        bit s;
        bit adv_now;
        s = m_h2[i];
        m_h2[i] = m_h1[i];
        m_h1[i] = key_bus.key_i[i];
        exp_press[i] = 1'b0; exp_release[i] = 1'b0; exp_repeat[i] = 1'b0;
        if (s == m_prev[i]) m_run[i]++;
        else                m_run[i] = 1;
        adv_now = m_level[i] && !s && !m_prev[i];
        if (!m_level[i] && !s && m_run[i] == D + 1) begin
          exp_press[i] = 1'b1;
          m_level[i]   = 1'b1;
          m_adv[i]     = 0;
        end else if (m_level[i] && s && m_run[i] == D + 1) begin
          exp_release[i] = 1'b1;
          m_level[i]     = 1'b0;
        end else if (adv_now) begin
          m_adv[i]++;
          if (H > 0 && (m_adv[i] == H || (m_adv[i] > H && (m_adv[i] - H) % R == 0)))
            exp_repeat[i] = 1'b1;
        end
        m_prev[i] = s;
      end
    end
  end

  function automatic logic [4*N-1:0] dut_vec();
    return {key_bus.state_o, key_bus.press_o, key_bus.release_o, key_bus.repeat_o};
  endfunction

  function automatic logic [4*N-1:0] exp_vec();
    return {m_level, exp_press, exp_release, exp_repeat};
  endfunction

  task automatic tick();
    @(negedge clk100_i);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstn_i = 1'b0;
    key_bus.key_i = '1;
    repeat (3) tick();
    tests_run++;
    if (dut_vec() !== '0) begin
      tests_failed++;
      $display("FAIL reset_hold dut=%b want=0", dut_vec());
    end
    rstn_i = 1'b1;
    repeat (5) begin
      tick();
      tests_run++;
      if (dut_vec() !== '0) begin
        tests_failed++;
        $display("FAIL reset_idle dut=%b want=0", dut_vec());
      end
    end
  endtask

  task automatic test_single_press();
    int first_press, first_rel, presses, releases;
    first_press = -1; first_rel = -1; presses = 0; releases = 0;
    key_bus.key_i = 2'b10;
    for (int n = 1; n <= 18; n++) begin
      tick();
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL single_press t=%0t dut=%b model=%b", $time, dut_vec(), exp_vec());
      end
      tests_run++;
      if ({key_bus.state_o[1], key_bus.press_o[1], key_bus.release_o[1], key_bus.repeat_o[1]} !== 4'b0) begin
        tests_failed++;
        $display("FAIL key1_quiet t=%0t key1 outputs active, want 0", $time);
      end
      if (key_bus.press_o[0]) begin
        presses++;
        if (first_press < 0) first_press = n;
      end
    end
    tests_run++;
    if (first_press != D + 3) begin
      tests_failed++;
      $display("FAIL press_latency got=%0d want=%0d", first_press, D + 3);
    end
    tests_run++;
    if (presses != 1 || key_bus.state_o[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL press_single presses=%0d state=%b want 1/1", presses, key_bus.state_o[0]);
    end
    key_bus.key_i = 2'b11;
    for (int n = 1; n <= 12; n++) begin
      tick();
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL single_release t=%0t dut=%b model=%b", $time, dut_vec(), exp_vec());
      end
      if (key_bus.release_o[0]) begin
        releases++;
        if (first_rel < 0) first_rel = n;
      end
    end
    tests_run++;
    if (first_rel != D + 3 || releases != 1 || key_bus.state_o[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL release_latency got=%0d cnt=%0d want=%0d cnt=1", first_rel, releases, D + 3);
    end
  endtask

  task automatic test_glitch();
    int presses;
    presses = 0;
    key_bus.key_i = 2'b10;
    for (int n = 0; n < 16; n++) begin
      if (n == 3) key_bus.key_i = 2'b11;
      tick();
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL glitch t=%0t dut=%b model=%b", $time, dut_vec(), exp_vec());
      end
      if (key_bus.press_o[0] || key_bus.state_o[0]) presses++;
    end
    tests_run++;
    if (presses != 0) begin
      tests_failed++;
      $display("FAIL glitch_no_press active_cycles=%0d want=0", presses);
    end
  endtask

  task automatic test_auto_repeat();
    bit seen;
    int reps, bad_pos;
    seen = 0; reps = 0; bad_pos = 0;
    key_bus.key_i = 2'b10;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      seen = key_bus.press_o[0];
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL repeat_press_timeout press_o[0]=0 want 1");
    end
    for (int j = 1; j <= 59; j++) begin
      bit want;
      tick();
      want = (j >= H) && ((j - H) % R == 0);
      if (key_bus.repeat_o[0]) reps++;
      if (key_bus.repeat_o[0] !== want) bad_pos++;
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL auto_repeat j=%0d dut=%b model=%b", j, dut_vec(), exp_vec());
      end
    end
    tests_run++;
    if (reps != 8 || bad_pos != 0) begin
      tests_failed++;
      $display("FAIL repeat_schedule pulses=%0d misplaced=%0d want 8/0", reps, bad_pos);
    end
    key_bus.key_i = 2'b11;
    repeat (10) tick();
  endtask

  task automatic test_simultaneous();
    logic [N-1:0] got_p, got_r;
    got_p = '0; got_r = '0;
    key_bus.key_i = 2'b00;
    for (int n = 0; n < 20 && got_p == '0; n++) begin
      tick();
      got_p = key_bus.press_o;
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL simul_press t=%0t dut=%b model=%b", $time, dut_vec(), exp_vec());
      end
    end
    tests_run++;
    if (got_p !== 2'b11) begin
      tests_failed++;
      $display("FAIL simul_press_mask got=%b want=11", got_p);
    end
    repeat (3) tick();
    key_bus.key_i = 2'b11;
    for (int n = 0; n < 20 && got_r == '0; n++) begin
      tick();
      got_r = key_bus.release_o;
    end
    tests_run++;
    if (got_r !== 2'b11) begin
      tests_failed++;
      $display("FAIL simul_release_mask got=%b want=11", got_r);
    end
    repeat (4) tick();
  endtask

  task automatic test_bounce();
    int reps, rels, exp_reps;
    reps = 0; rels = 0; exp_reps = 0;
    key_bus.key_i = 2'b10;
    for (int n = 0; n < 75; n++) begin
      // Bounce after the first repeat has fired: two cycles high, then low.
      if (n == 35) key_bus.key_i = 2'b11;
      if (n == 37) key_bus.key_i = 2'b10;
      tick();
      if (key_bus.repeat_o[0])  reps++;
      if (key_bus.release_o[0]) rels++;
      if (exp_repeat[0])        exp_reps++;
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL bounce t=%0t dut=%b model=%b", $time, dut_vec(), exp_vec());
      end
    end
    tests_run++;
    if (rels != 0 || reps != exp_reps || reps < 2) begin
      tests_failed++;
      $display("FAIL bounce_summary releases=%0d repeats=%0d want 0/%0d", rels, reps, exp_reps);
    end
    key_bus.key_i = 2'b11;
    repeat (10) tick();
  endtask

  task automatic test_reset_held();
    int first_press, rels;
    first_press = -1; rels = 0;
    key_bus.key_i = 2'b10;
    repeat (D + 8) tick();
    tests_run++;
    if (key_bus.state_o[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_held_pre state=%b want=1", key_bus.state_o[0]);
    end
    #2 rstn_i = 1'b0;
    #1;
    tests_run++;
    if (dut_vec() !== '0) begin
      tests_failed++;
      $display("FAIL rst_async dut=%b want=0", dut_vec());
    end
    repeat (3) begin
      tick();
      if (key_bus.release_o !== '0) rels++;
    end
    rstn_i = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      tick();
      if (key_bus.release_o !== '0) rels++;
      if (key_bus.press_o[0] && first_press < 0) first_press = n;
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL rst_repress t=%0t dut=%b model=%b", $time, dut_vec(), exp_vec());
      end
    end
    tests_run++;
    if (first_press != D + 3 || rels != 0) begin
      tests_failed++;
      $display("FAIL rst_repress_latency got=%0d rel=%0d want=%0d rel=0", first_press, rels, D + 3);
    end
    key_bus.key_i = 2'b11;
    repeat (10) tick();
  endtask

  task automatic test_random();
    int rem [N];
    logic [N-1:0] val;
    val = '1;
    for (int i = 0; i < N; i++) rem[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0) begin
          val[i] = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 2) == 0) rem[i] = int'($urandom_range(1, D + 1));
          else                           rem[i] = int'($urandom_range(D + 2, 70));
        end
        rem[i]--;
      end
      key_bus.key_i = val;
      tick();
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL random c=%0d dut=%b model=%b", c, dut_vec(), exp_vec());
      end
    end
    key_bus.key_i = '1;
    repeat (10) tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    key_bus.key_i = '1;
    test_reset();
    test_single_press();
    test_glitch();
    test_auto_repeat();
    test_simultaneous();
    test_bounce();
    test_reset_held();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
